// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared size/error codes, FSM states and the legality check for the LSU
// Exports SZ_* size codes, ERR_* completion codes, lsu_state_e and is_illegal().
package load_store_unit_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL = 2'b11;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  typedef enum logic [1:0] {LSU_IDLE, LSU_RD, LSU_WR, LSU_DONE} lsu_state_e;
  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] lane);
    return size == SZ_ILL || (size == SZ_HALF && lane[0]) || (size == SZ_WORD && lane != 2'b00);
  endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: pipeline request bus and word-addressed data-memory bus of the LSU
// master = the LSU (consumes mem_* requests, initiates dm_* accesses); slave = pipeline plus memory.
interface load_store_unit_if #(parameter int DM_AW = 10);
  logic mem_req, mem_we, mem_unsigned, mem_done;
  logic [1:0] mem_size, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic dm_req, dm_we, dm_ack;
  logic [DM_AW-1:0] dm_addr;
  logic [31:0] dm_wdata, dm_rdata;
  modport master (
    input mem_req, mem_we, mem_size, mem_unsigned, mem_addr, mem_wdata, dm_rdata, dm_ack,
    output mem_done, mem_rdata, mem_err, dm_req, dm_we, dm_addr, dm_wdata
  );
  modport slave (
    output mem_req, mem_we, mem_size, mem_unsigned, mem_addr, mem_wdata, dm_rdata, dm_ack,
    input mem_done, mem_rdata, mem_err, dm_req, dm_we, dm_addr, dm_wdata
  );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// lsu_lane_align: extracts/extends a load lane and merges store data into a memory word
// In: i_addr (byte lane), i_size, i_unsigned, i_word (memory word), i_wdata (right-aligned store data)
// Out: o_load (extended load value), o_merged (word with the addressed lane replaced)
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  i_addr,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_word,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);
  logic [7:0] w_byte;
  logic [15:0] w_half;
  logic [31:0] w_mask, w_data;
  assign w_byte = 8'(i_word >> {i_addr, 3'b000});
  assign w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];
  assign o_load = i_size == SZ_BYTE ? {{24{w_byte[7] & ~i_unsigned}}, w_byte} :
                  i_size == SZ_HALF ? {{16{w_half[15] & ~i_unsigned}}, w_half} : i_word;
  // replicate the store data across all lanes and let the mask pick the addressed one
  assign w_mask = i_size == SZ_BYTE ? 32'h0000_00ff << {i_addr, 3'b000} :
                  i_size == SZ_HALF ? (i_addr[1] ? 32'hffff_0000 : 32'h0000_ffff) : '1;
  assign w_data = i_size == SZ_BYTE ? {4{i_wdata[7:0]}} : {2{i_wdata}};
  assign o_merged = (i_word & ~w_mask) | (w_data & w_mask);
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage initiator issuing word accesses with sub-word extraction and RMW stores
// Ports: clk, rst_n (async active-low), bus (load_store_unit_if.master: mem_* pipeline side, dm_* memory side)
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DM_AW = 10,
  parameter int ACK_TIMEOUT = 15
) (
  input logic clk,
  input logic rst_n,
  load_store_unit_if.master bus
);
  lsu_state_e r_state, w_next;
  logic [1:0] r_lane, r_size, r_err;
  logic r_we, r_uns, r_dm_we;
  logic [15:0] r_wdata;
  logic [31:0] r_rdata, r_dm_wdata, w_load, w_merged;
  logic [DM_AW-1:0] r_dm_addr;
  logic [7:0] r_cnt;
  logic w_busy, w_tmo, w_accept, w_ill;
  assign w_busy = r_state == LSU_RD || r_state == LSU_WR;
  // an ack in the final allowed cycle still wins over the timeout
  assign w_tmo = w_busy && !bus.dm_ack && r_cnt == 8'(ACK_TIMEOUT - 1);
  assign w_accept = r_state == LSU_IDLE && bus.mem_req;
  assign w_ill = is_illegal(bus.mem_size, bus.mem_addr[1:0]);
  lsu_lane_align u_align (
    .i_addr(r_lane),
    .i_size(r_size),
    .i_unsigned(r_uns),
    .i_word(bus.dm_rdata),
    .i_wdata(r_wdata),
    .o_load(w_load),
    .o_merged(w_merged)
  );
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      LSU_IDLE: w_next = !bus.mem_req ? LSU_IDLE : w_ill ? LSU_DONE :
                         (bus.mem_we && bus.mem_size == SZ_WORD) ? LSU_WR : LSU_RD;
      LSU_RD: w_next = bus.dm_ack ? (r_we ? LSU_WR : LSU_DONE) : w_tmo ? LSU_DONE : LSU_RD;
      LSU_WR: w_next = (bus.dm_ack || w_tmo) ? LSU_DONE : LSU_WR;
      default: w_next = LSU_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LSU_IDLE;
      r_lane <= '0;
      r_size <= '0;
      r_err <= '0;
      r_we <= 1'b0;
      r_uns <= 1'b0;
      r_dm_we <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_dm_wdata <= '0;
      r_dm_addr <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= (w_next != r_state) ? 8'd0 : r_cnt + 8'(w_busy);
      if (w_accept) begin
        r_lane <= bus.mem_addr[1:0];
        r_size <= bus.mem_size;
        r_we <= bus.mem_we;
        r_uns <= bus.mem_unsigned;
        r_wdata <= bus.mem_wdata[15:0];
        r_rdata <= '0;
        r_err <= w_ill ? ERR_ALIGN : ERR_NONE;
      end
      if (w_accept && !w_ill) begin
        r_dm_addr <= bus.mem_addr[DM_AW+1:2];
        r_dm_we <= w_next == LSU_WR;
      end
      if (w_accept && w_next == LSU_WR) r_dm_wdata <= bus.mem_wdata;
      if (r_state == LSU_RD && bus.dm_ack) begin
        if (r_we) begin
          r_dm_wdata <= w_merged;
          r_dm_we <= 1'b1;
        end else r_rdata <= w_load;
      end
      if (w_tmo) r_err <= ERR_TIMEOUT;
    end
  end
  assign bus.mem_done = r_state == LSU_DONE;
  assign bus.mem_rdata = r_rdata;
  assign bus.mem_err = r_err;
  assign bus.dm_req = w_busy;
  assign bus.dm_we = r_dm_we;
  assign bus.dm_addr = r_dm_addr;
  assign bus.dm_wdata = r_dm_wdata;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized and directed checks of load_store_unit against an arithmetic reference model
module tb_load_store_unit;
  localparam int DM_AW = 10;
  localparam int TO = 15;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  load_store_unit_if #(.DM_AW(DM_AW)) bus ();
  load_store_unit #(.DM_AW(DM_AW), .ACK_TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [31:0] mem [1<<DM_AW];
  logic [31:0] ref_mem [1<<DM_AW];
  int dly = 0;
  bit noise = 1'b0;
  int wcnt = 0;
  int req_cyc = 0;
  int wr_acks = 0;
  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  initial begin
    bit was_req, was_ack;
    bus.dm_ack = 1'b0;
    bus.dm_rdata = '0;
    forever begin
      @(posedge clk);
      was_req = bus.dm_req;
      was_ack = bus.dm_ack;
      if (was_req) req_cyc++;
      if (was_req && was_ack && bus.dm_we) begin
        mem[bus.dm_addr] = bus.dm_wdata;
        wr_acks++;
      end
      #1;
      wcnt = (was_req && !was_ack) ? wcnt + 1 : 0;
      if (bus.dm_req) begin
        bus.dm_ack = wcnt >= dly;
        bus.dm_rdata = bus.dm_ack ? mem[bus.dm_addr] : $urandom;
      end else begin
        bus.dm_ack = noise && $urandom_range(0, 3) == 0;
        bus.dm_rdata = $urandom;
      end
    end
  end
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input int d);
    logic [DM_AW-1:0] wa;
    logic [31:0] old, b, h, exp_rd;
    logic [1:0] exp_err;
    int sh, hs, exp_lat, lat, rq0, wr0;
    bit ill, to, seen;
    wa = addr[DM_AW+1:2];
    old = ref_mem[wa];
    sh = 8 * int'(addr[1:0]);
    hs = 16 * int'(addr[1]);
    b = (old >> sh) & 32'hff;
    h = (old >> hs) & 32'hffff;
    ill = sz == 2'd3 || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0);
    to = d >= TO;
    exp_rd = 0;
    exp_err = ill ? 2'd1 : to ? 2'd2 : 2'd0;
    exp_lat = ill ? 1 : to ? 1 + TO : (we && sz != 2'd2) ? 2 * d + 3 : d + 2;
    if (!ill && !to) begin
      if (!we)
        exp_rd = sz == 2'd0 ? ((!uns && b >= 128) ? b - 256 : b) :
                 sz == 2'd1 ? ((!uns && h >= 32768) ? h - 65536 : h) : old;
      else
        ref_mem[wa] = sz == 2'd0 ? old - (b << sh) + ((wd & 32'hff) << sh) :
                      sz == 2'd1 ? old - (h << hs) + ((wd & 32'hffff) << hs) : wd;
    end
    dly = d;
    rq0 = req_cyc;
    wr0 = wr_acks;
    bus.mem_we = we;
    bus.mem_size = sz;
    bus.mem_unsigned = uns;
    bus.mem_addr = addr;
    bus.mem_wdata = wd;
    bus.mem_req = 1'b1;
    seen = 1'b0;
    lat = 0;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.mem_done) begin
        lat = i;
        seen = 1'b1;
        break;
      end
    end
    bus.mem_req = 1'b0;
    bus.mem_we = 1'($urandom);
    bus.mem_wdata = $urandom;
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("rdata", bus.mem_rdata, exp_rd);
    chk("err", 32'(bus.mem_err), 32'(exp_err));
    chk("req_cycles", 32'(req_cyc - rq0), 32'(exp_lat - 1));
    chk("writes", 32'(wr_acks - wr0), (we && !ill && !to) ? 32'd1 : 32'd0);
    chk("mem_word", mem[wa], ref_mem[wa]);
    @(negedge clk);
    chk("done_pulse", 32'(bus.mem_done), 32'd0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] a;
    logic [1:0] sz;
    int d;
    bit seen;
    bus.mem_req = 1'b0;
    bus.mem_we = 1'b0;
    bus.mem_size = 2'd0;
    bus.mem_unsigned = 1'b0;
    bus.mem_addr = '0;
    bus.mem_wdata = '0;
    for (int i = 0; i < (1 << DM_AW); i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    #12;
    chk("rst_done", 32'(bus.mem_done), 32'd0);
    chk("rst_rdata", bus.mem_rdata, 32'd0);
    chk("rst_err", 32'(bus.mem_err), 32'd0);
    chk("rst_dm_req", 32'(bus.dm_req), 32'd0);
    chk("rst_dm_we", 32'(bus.dm_we), 32'd0);
    chk("rst_dm_addr", 32'(bus.dm_addr), 32'd0);
    chk("rst_dm_wdata", bus.dm_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_req(1, 2'd2, 0, 32'h010, 32'hdeadbeef, 0);
    do_req(0, 2'd2, 0, 32'h010, 32'h0, 0);
    chk("plan_word", ref_mem[4], 32'hdeadbeef);
    mem[4] = 32'h11223344;
    ref_mem[4] = 32'h11223344;
    do_req(1, 2'd0, 0, 32'h013, 32'h00000080, 0);
    chk("plan_byte_merge", mem[4], 32'h80223344);
    do_req(0, 2'd0, 0, 32'h013, 32'h0, 0);
    do_req(0, 2'd0, 1, 32'h013, 32'h0, 0);
    mem[4] = 32'h11223344;
    ref_mem[4] = 32'h11223344;
    do_req(1, 2'd1, 0, 32'h012, 32'h5a5aa5a5, 0);
    chk("plan_half_merge", mem[4], 32'ha5a53344);
    do_req(0, 2'd1, 0, 32'h012, 32'h0, 0);
    do_req(0, 2'd1, 1, 32'h012, 32'h0, 0);
    do_req(0, 2'd2, 0, 32'hffff_f010, 32'h0, 0);
    do_req(0, 2'd1, 0, 32'h011, 32'h0, 0);
    do_req(0, 2'd2, 0, 32'h012, 32'h0, 0);
    do_req(0, 2'd3, 0, 32'h010, 32'h0, 0);
    do_req(1, 2'd1, 0, 32'h011, 32'h1234, 0);
    do_req(0, 2'd2, 0, 32'h020, 32'h0, 3);
    do_req(1, 2'd0, 0, 32'h021, 32'h77, 3);
    do_req(0, 2'd1, 0, 32'h022, 32'h0, TO - 1);
    do_req(1, 2'd1, 0, 32'h026, 32'hbeef, TO - 1);
    do_req(0, 2'd2, 0, 32'h024, 32'h0, TO);
    do_req(1, 2'd0, 0, 32'h025, 32'h99, 255);
    do_req(1, 2'd2, 0, 32'h028, 32'hcafef00d, 255);
    mem[4] = 32'h11223344;
    ref_mem[4] = 32'h11223344;
    dly = 5;
    bus.mem_we = 1'b1;
    bus.mem_size = 2'd0;
    bus.mem_unsigned = 1'b0;
    bus.mem_addr = 32'h013;
    bus.mem_wdata = 32'h55;
    bus.mem_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.dm_req && bus.dm_we) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rmw_reached_wr", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    bus.mem_req = 1'b0;
    #1;
    chk("rst_mid_dm_req", 32'(bus.dm_req), 32'd0);
    chk("rst_mid_dm_we", 32'(bus.dm_we), 32'd0);
    chk("rst_mid_done", 32'(bus.mem_done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_mem", mem[4], ref_mem[4]);
    rst_n = 1'b1;
    @(negedge clk);
    do_req(0, 2'd0, 0, 32'h013, 32'h0, 0);
    do_req(1, 2'd0, 0, 32'h013, 32'h55, 1);
    noise = 1'b1;
    repeat (150) begin
      a = $urandom;
      a[DM_AW+1:2] = DM_AW'($urandom_range(0, 15));
      sz = $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 2) != 0) a[1:0] = sz == 2'd2 ? 2'd0 : sz == 2'd1 ? {a[1], 1'b0} : a[1:0];
      d = $urandom_range(0, 9) == 0 ? ($urandom_range(0, 1) == 1 ? TO : 255) : int'($urandom_range(0, 3));
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom, d);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
